// File: rtl/stack_pkg.sv
// Shared constants for the operand stack: default geometry and the
// effective-operation encoding used by stack_unit and its bench.
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;

    typedef logic [2:0] op_t;

    localparam op_t OP_NONE = 3'd0;
    localparam op_t OP_PUSH = 3'd1;
    localparam op_t OP_POP  = 3'd2;
    localparam op_t OP_TOP  = 3'd3;
    localparam op_t OP_REPL = 3'd4;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x WIDTH register array with one synchronous write
// port and one asynchronous read port. Contents are never cleared.
module stack_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack with registered top-of-stack output, occupancy count and
// sticky overflow/underflow flags.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    localparam int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             top,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic [PTR_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    // Strobes are single-cycle requests with no back-pressure: every strobe is
    // consumed in the cycle it is seen, and d_out reflects a top/pop one cycle later.
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_m1;
    logic [WIDTH-1:0] tos;
    op_t              op;
    logic             set_ovf;
    logic             set_unf;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;

    assign sp_m1 = sp - PTR_W'(1);
    assign count = sp;
    assign empty = (sp == '0);
    assign full  = (sp == PTR_W'(DEPTH));

    always_comb begin
        op      = OP_NONE;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (push && pop) begin
            if (!empty) begin
                op = OP_REPL;
            end else begin
                // DEPTH >= 2, so an empty stack is never full: the push lands.
                op      = OP_PUSH;
                set_unf = 1'b1;
            end
        end else if (pop) begin
            if (!empty) op = OP_POP;
            else        set_unf = 1'b1;
        end else if (push) begin
            if (!full) op = OP_PUSH;
            else       set_ovf = 1'b1;
        end else if (top) begin
            if (!empty) op = OP_TOP;
            else        set_unf = 1'b1;
        end
    end

    assign mem_we    = !rst && (op == OP_PUSH || op == OP_REPL);
    assign mem_waddr = (op == OP_REPL) ? sp_m1[AW-1:0] : sp[AW-1:0];

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (d_in),
        .raddr (sp_m1[AW-1:0]),
        .rdata (tos)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            d_out     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (op)
                OP_PUSH: sp <= sp + PTR_W'(1);
                OP_POP: begin
                    sp    <= sp_m1;
                    d_out <= tos;
                end
                OP_TOP, OP_REPL: d_out <= tos;
                default: ;
            endcase
            overflow  <= overflow | set_ovf;
            underflow <= underflow | set_unf;
        end
    end

endmodule
